// File: rtl/scr1_dmem_vlsu_arb.sv
// scr1_dmem_vlsu_arb: shares the single DMEM port between the scalar LSU and the vector LSU.
// One transaction is in flight at a time. Ack and response are routed back only to the owner.
// Optional feature: define SCR1_DMEM_ARB_RR_EN for round-robin arbitration on simultaneous
// requests. Without it, LSU has fixed priority and a consecutive-grant limit prevents VLSU starvation.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_arb_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_vlsu_arb
  import scr1_dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned STARVE_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // scalar LSU
  input  logic                         lsu2arb_req,
  input  type_scr1_mem_cmd_e           lsu2arb_cmd,
  input  type_scr1_mem_width_e         lsu2arb_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0] lsu2arb_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] lsu2arb_wdata,
  output logic                         arb2lsu_req_ack,
  output logic [`SCR1_DMEM_DWIDTH-1:0] arb2lsu_rdata,
  output type_scr1_mem_resp_e          arb2lsu_resp,
  // vector LSU
  input  logic                         vlsu2arb_req,
  input  type_scr1_mem_cmd_e           vlsu2arb_cmd,
  input  type_scr1_mem_width_e         vlsu2arb_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0] vlsu2arb_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] vlsu2arb_wdata,
  output logic                         arb2vlsu_req_ack,
  output logic [`SCR1_DMEM_DWIDTH-1:0] arb2vlsu_rdata,
  output type_scr1_mem_resp_e          arb2vlsu_resp,
  // DMEM
  output logic                         arb2dmem_req,
  output type_scr1_mem_cmd_e           arb2dmem_cmd,
  output type_scr1_mem_width_e         arb2dmem_width,
  output logic [`SCR1_DMEM_AWIDTH-1:0] arb2dmem_addr,
  output logic [`SCR1_DMEM_DWIDTH-1:0] arb2dmem_wdata,
  input  logic                         dmem2arb_req_ack,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] dmem2arb_rdata,
  input  type_scr1_mem_resp_e          dmem2arb_resp
);

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'b00,
    ARB_REQ_HOLD  = 2'b01,
    ARB_WAIT_RESP = 2'b10
  } arb_state_e;

  localparam logic SEL_LSU  = 1'b0;
  localparam logic SEL_VLSU = 1'b1;

  localparam bit                  STARVE_EN  = (STARVE_LIMIT != 0);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_LIMIT[STARVE_W-1:0];
  localparam logic [STARVE_W-1:0] CNT_SAT    = {STARVE_W{1'b1}};

  arb_state_e          state;
  arb_state_e          state_next;
  logic                sel;
  logic [STARVE_W-1:0] starve_cnt;
  logic                any_req;
  logic                prio_winner;
  logic                winner;
  logic                starve_hit;
  logic                loser_req;
  logic                cur_sel;
  logic                cur_req;
  logic                dmem_ack;
  logic                grant;

  assign any_req    = lsu2arb_req | vlsu2arb_req;
  assign starve_hit = STARVE_EN && (starve_cnt == STARVE_MAX)
                      && ((sel == SEL_LSU) ? vlsu2arb_req : lsu2arb_req);
  assign loser_req  = (winner == SEL_LSU) ? vlsu2arb_req : lsu2arb_req;
  assign grant      = (state == ARB_IDLE) & any_req;

  // The requester is chosen combinationally in IDLE and frozen in sel afterwards
  assign cur_sel  = (state == ARB_IDLE) ? winner : sel;
  assign cur_req  = (cur_sel == SEL_LSU) ? lsu2arb_req : vlsu2arb_req;
  assign dmem_ack = dmem2arb_req_ack & arb2dmem_req;

`ifdef SCR1_DMEM_ARB_RR_EN
  logic last_grant;

  // Round-robin: on a tie the side that did not get the last ack wins
  always_comb begin
    prio_winner = lsu2arb_req ? SEL_LSU : SEL_VLSU;
    if (lsu2arb_req && vlsu2arb_req) begin
      prio_winner = ~last_grant;
    end
  end

  // Remember which side was last accepted by DMEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SEL_LSU;
    end else if (dmem_ack) begin
      last_grant <= cur_sel;
    end
  end
`else
  // Fixed priority: LSU always beats VLSU unless the starvation rule intervenes
  always_comb begin
    prio_winner = lsu2arb_req ? SEL_LSU : SEL_VLSU;
  end
`endif

  // Starvation override hands the next grant to the side that has been waiting
  always_comb begin
    winner = prio_winner;
    if (starve_hit) begin
      winner = ~sel;
    end
  end

  // FSM state, owner and starvation counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      sel        <= SEL_LSU;
      starve_cnt <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        sel <= winner;
        if ((winner != sel) && (starve_cnt != '0)) begin
          starve_cnt <= '0;
        end else if (loser_req) begin
          starve_cnt <= (starve_cnt == CNT_SAT) ? starve_cnt : starve_cnt + STARVE_W'(1);
        end else begin
          starve_cnt <= '0;
        end
      end
    end
  end

  // Next-state logic: request handshake, then wait for the DMEM response
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (dmem_ack) begin
          state_next = ARB_WAIT_RESP;
        end else if (any_req) begin
          state_next = ARB_REQ_HOLD;
        end
      end
      ARB_REQ_HOLD: begin
        if (dmem_ack) begin
          state_next = ARB_WAIT_RESP;
        end
      end
      ARB_WAIT_RESP: begin
        if ((dmem2arb_resp == SCR1_MEM_RESP_RDY_OK) || (dmem2arb_resp == SCR1_MEM_RESP_RDY_ER)) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // DMEM request mux from the selected requester
  always_comb begin
    arb2dmem_req   = (state != ARB_WAIT_RESP) & cur_req;
    arb2dmem_cmd   = (cur_sel == SEL_LSU) ? lsu2arb_cmd   : vlsu2arb_cmd;
    arb2dmem_width = (cur_sel == SEL_LSU) ? lsu2arb_width : vlsu2arb_width;
    arb2dmem_addr  = (cur_sel == SEL_LSU) ? lsu2arb_addr  : vlsu2arb_addr;
    arb2dmem_wdata = (cur_sel == SEL_LSU) ? lsu2arb_wdata : vlsu2arb_wdata;
  end

  // Ack and response go only to the owner; responses only count while waiting for one
  always_comb begin
    arb2lsu_req_ack  = dmem_ack & (cur_sel == SEL_LSU);
    arb2vlsu_req_ack = dmem_ack & (cur_sel == SEL_VLSU);
    arb2lsu_resp     = SCR1_MEM_RESP_NOTRDY;
    arb2lsu_rdata    = '0;
    arb2vlsu_resp    = SCR1_MEM_RESP_NOTRDY;
    arb2vlsu_rdata   = '0;
    if (state == ARB_WAIT_RESP) begin
      if (sel == SEL_LSU) begin
        arb2lsu_resp  = dmem2arb_resp;
        arb2lsu_rdata = dmem2arb_rdata;
      end else begin
        arb2vlsu_resp  = dmem2arb_resp;
        arb2vlsu_rdata = dmem2arb_rdata;
      end
    end
  end

endmodule

// File: tb/tb_scr1_dmem_vlsu_arb.sv
// tb_scr1_dmem_vlsu_arb: directed vector bench for the LSU/VLSU DMEM arbiter.
// Honours SCR1_DMEM_ARB_RR_EN for the expected grant order under continuous contention.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module tb_scr1_dmem_vlsu_arb;
  import scr1_dmem_arb_pkg::*;

  localparam logic [1:0] NR = 2'b00;
  localparam logic [1:0] OK = 2'b01;
  localparam logic [1:0] ER = 2'b10;
  localparam logic [31:0] LADDR = 32'h0000_0100;
  localparam logic [31:0] VADDR = 32'h0000_0200;

  logic clk = 1'b0;
  logic rst_n;

  logic                         lsu2arb_req;
  type_scr1_mem_cmd_e           lsu2arb_cmd;
  type_scr1_mem_width_e         lsu2arb_width;
  logic [`SCR1_DMEM_AWIDTH-1:0] lsu2arb_addr;
  logic [`SCR1_DMEM_DWIDTH-1:0] lsu2arb_wdata;
  logic                         arb2lsu_req_ack;
  logic [`SCR1_DMEM_DWIDTH-1:0] arb2lsu_rdata;
  type_scr1_mem_resp_e          arb2lsu_resp;
  logic                         vlsu2arb_req;
  type_scr1_mem_cmd_e           vlsu2arb_cmd;
  type_scr1_mem_width_e         vlsu2arb_width;
  logic [`SCR1_DMEM_AWIDTH-1:0] vlsu2arb_addr;
  logic [`SCR1_DMEM_DWIDTH-1:0] vlsu2arb_wdata;
  logic                         arb2vlsu_req_ack;
  logic [`SCR1_DMEM_DWIDTH-1:0] arb2vlsu_rdata;
  type_scr1_mem_resp_e          arb2vlsu_resp;
  logic                         arb2dmem_req;
  type_scr1_mem_cmd_e           arb2dmem_cmd;
  type_scr1_mem_width_e         arb2dmem_width;
  logic [`SCR1_DMEM_AWIDTH-1:0] arb2dmem_addr;
  logic [`SCR1_DMEM_DWIDTH-1:0] arb2dmem_wdata;
  logic                         dmem2arb_req_ack;
  logic [`SCR1_DMEM_DWIDTH-1:0] dmem2arb_rdata;
  type_scr1_mem_resp_e          dmem2arb_resp;

  scr1_dmem_vlsu_arb #(.STARVE_LIMIT(4), .STARVE_W(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lsu2arb_req      (lsu2arb_req),
    .lsu2arb_cmd      (lsu2arb_cmd),
    .lsu2arb_width    (lsu2arb_width),
    .lsu2arb_addr     (lsu2arb_addr),
    .lsu2arb_wdata    (lsu2arb_wdata),
    .arb2lsu_req_ack  (arb2lsu_req_ack),
    .arb2lsu_rdata    (arb2lsu_rdata),
    .arb2lsu_resp     (arb2lsu_resp),
    .vlsu2arb_req     (vlsu2arb_req),
    .vlsu2arb_cmd     (vlsu2arb_cmd),
    .vlsu2arb_width   (vlsu2arb_width),
    .vlsu2arb_addr    (vlsu2arb_addr),
    .vlsu2arb_wdata   (vlsu2arb_wdata),
    .arb2vlsu_req_ack (arb2vlsu_req_ack),
    .arb2vlsu_rdata   (arb2vlsu_rdata),
    .arb2vlsu_resp    (arb2vlsu_resp),
    .arb2dmem_req     (arb2dmem_req),
    .arb2dmem_cmd     (arb2dmem_cmd),
    .arb2dmem_width   (arb2dmem_width),
    .arb2dmem_addr    (arb2dmem_addr),
    .arb2dmem_wdata   (arb2dmem_wdata),
    .dmem2arb_req_ack (dmem2arb_req_ack),
    .dmem2arb_rdata   (dmem2arb_rdata),
    .dmem2arb_resp    (dmem2arb_resp)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  typedef struct {
    logic        l_req;
    logic        v_req;
    logic        v_wr;
    logic        ack;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        e_dreq;
    logic        chk_addr;
    logic [31:0] e_addr;
    logic        e_wr;
    logic        e_lack;
    logic        e_vack;
    logic [1:0]  e_lresp;
    logic [31:0] e_lrdata;
    logic [1:0]  e_vresp;
    logic [31:0] e_vrdata;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic lr, input logic vr, input logic vwr, input logic ack,
                              input logic [1:0] rsp, input logic [31:0] rd,
                              input logic edq, input logic ca, input logic [31:0] ea, input logic ewr,
                              input logic la, input logic va,
                              input logic [1:0] lrs, input logic [31:0] lrd,
                              input logic [1:0] vrs, input logic [31:0] vrd);
    vec_t v;
    v.l_req = lr;    v.v_req = vr;     v.v_wr = vwr;     v.ack = ack;
    v.resp = rsp;    v.rdata = rd;
    v.e_dreq = edq;  v.chk_addr = ca;  v.e_addr = ea;    v.e_wr = ewr;
    v.e_lack = la;   v.e_vack = va;
    v.e_lresp = lrs; v.e_lrdata = lrd; v.e_vresp = vrs;  v.e_vrdata = vrd;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    lsu2arb_req      = v.l_req;
    vlsu2arb_req     = v.v_req;
    vlsu2arb_cmd     = v.v_wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    dmem2arb_req_ack = v.ack;
    dmem2arb_resp    = type_scr1_mem_resp_e'(v.resp);
    dmem2arb_rdata   = v.rdata;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkField({tag, ".dreq"},   {31'b0, arb2dmem_req},     {31'b0, v.e_dreq});
    if (v.chk_addr) begin
      checkField({tag, ".addr"}, arb2dmem_addr,             v.e_addr);
      checkField({tag, ".cmd"},  {31'b0, arb2dmem_cmd},     {31'b0, v.e_wr});
    end
    checkField({tag, ".lack"},   {31'b0, arb2lsu_req_ack},  {31'b0, v.e_lack});
    checkField({tag, ".vack"},   {31'b0, arb2vlsu_req_ack}, {31'b0, v.e_vack});
    checkField({tag, ".lresp"},  {30'b0, arb2lsu_resp},     {30'b0, v.e_lresp});
    checkField({tag, ".lrdata"}, arb2lsu_rdata,             v.e_lrdata);
    checkField({tag, ".vresp"},  {30'b0, arb2vlsu_resp},    {30'b0, v.e_vresp});
    checkField({tag, ".vrdata"}, arb2vlsu_rdata,            v.e_vrdata);
  endtask

  // One cycle: drive after the falling edge, check combinational outputs before the rising edge
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(tag, v);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    applyStimulus(mk(0,0,0,0,NR,0, 0,0,0,0, 0,0,NR,0,NR,0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t  idle_v;
    logic  exp_v;
    idle_v = mk(0,0,0,0,NR,0, 0,0,0,0, 0,0,NR,0,NR,0);

    lsu2arb_cmd    = SCR1_MEM_CMD_RD;
    lsu2arb_width  = SCR1_MEM_WIDTH_WORD;
    lsu2arb_addr   = LADDR;
    lsu2arb_wdata  = 32'h1111_1111;
    vlsu2arb_width = SCR1_MEM_WIDTH_WORD;
    vlsu2arb_addr  = VADDR;
    vlsu2arb_wdata = 32'h2222_2222;
    applyStimulus(idle_v);
    rst_n = 1'b0;

    #2;
    checkOutput("reset", idle_v);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: LSU-only read, response two cycles after request, IDLE response ignored
    vecs.push_back(mk(1,0,0,1,NR,0,             1,1,LADDR,0, 1,0,NR,0,NR,0));
    vecs.push_back(mk(0,0,0,0,NR,0,             0,0,0,0,     0,0,NR,0,NR,0));
    vecs.push_back(mk(0,0,0,0,OK,32'hDEADBEEF,  0,0,0,0,     0,0,OK,32'hDEADBEEF,NR,0));
    vecs.push_back(mk(0,0,0,0,OK,32'h12345678,  0,0,0,0,     0,0,NR,0,NR,0));
    // Test 2: simultaneous requests, LSU first, VLSU on the bus the cycle after LSU response
    vecs.push_back(mk(1,1,0,1,NR,0,             1,1,LADDR,0, 1,0,NR,0,NR,0));
    vecs.push_back(mk(0,1,0,0,OK,32'hA5A5A5A5,  0,0,0,0,     0,0,OK,32'hA5A5A5A5,NR,0));
    vecs.push_back(mk(0,1,0,0,OK,32'hBAD0BAD0,  1,1,VADDR,0, 0,0,NR,0,NR,0));
    vecs.push_back(mk(0,1,0,1,OK,32'hBAD1BAD1,  1,1,VADDR,0, 0,1,NR,0,NR,0));
    vecs.push_back(mk(0,0,0,0,OK,32'h5A5A5A5A,  0,0,0,0,     0,0,NR,0,OK,32'h5A5A5A5A));
    // Test 6a: VLSU write answered with an error, routed to VLSU only
    vecs.push_back(mk(0,1,1,1,NR,0,             1,1,VADDR,1, 0,1,NR,0,NR,0));
    vecs.push_back(mk(0,0,0,0,ER,32'hC0FFEE00,  0,0,0,0,     0,0,NR,0,ER,32'hC0FFEE00));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Test 6b: reset while waiting for a response; the late response must not be forwarded
    step("rst_req", mk(0,1,0,1,NR,0, 1,1,VADDR,0, 0,1,NR,0,NR,0));
    @(negedge clk);
    applyStimulus(mk(0,0,0,0,OK,32'h77777777, 0,0,0,0, 0,0,NR,0,NR,0));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_in", idle_v);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(0,0,0,0,OK,32'h11111111, 0,0,0,0, 0,0,NR,0,NR,0));
    #1;
    checkOutput("rst_late", idle_v);
    step("rst_idle", idle_v);

    // Test 5: DMEM withholds ack; LSU stays on the bus while VLSU waits
    for (int i = 0; i < 4; i++) begin
      step($sformatf("hold%0d", i),
           mk(1, (i >= 1), 0, (i == 3), NR, 0, 1,1,LADDR,0, (i == 3), 0, NR,0,NR,0));
    end
    step("hold_resp", mk(0,1,0,0,OK,32'h00000055, 0,0,0,0,     0,0,OK,32'h00000055,NR,0));
    step("hold_vreq", mk(0,1,0,1,NR,0,            1,1,VADDR,0, 0,1,NR,0,NR,0));
    step("hold_vrsp", mk(0,0,0,0,OK,32'h00000066, 0,0,0,0,     0,0,NR,0,OK,32'h00000066));

    // Tests 3/4: continuous contention, one grant every two cycles
    resetPulse();
    for (int g = 0; g < 10; g++) begin
`ifdef SCR1_DMEM_ARB_RR_EN
      exp_v = (g % 2 == 0);
`else
      exp_v = (g == 4) || (g == 9);
`endif
      @(negedge clk);
      applyStimulus(mk(1,1,0,1,NR,0, 0,0,0,0, 0,0,NR,0,NR,0));
      #1;
      checkField($sformatf("grant%0d.vack", g), {31'b0, arb2vlsu_req_ack}, {31'b0, exp_v});
      checkField($sformatf("grant%0d.lack", g), {31'b0, arb2lsu_req_ack},  {31'b0, ~exp_v});
      step($sformatf("grant%0d.rsp", g),
           mk(1,1,0,0,OK,32'h0000_0A00 + g, 0,0,0,0, 0,0,
              exp_v ? NR : OK, exp_v ? 32'h0 : 32'h0000_0A00 + g,
              exp_v ? OK : NR, exp_v ? 32'h0000_0A00 + g : 32'h0));
    end

    @(negedge clk);
    applyStimulus(idle_v);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
